// File: rtl/sonic_pkg.sv
// Shared constants and the combinational x^58+x^39+1 descrambler used by the upstream path.
// descramble64 returns {descrambled word, next 58-bit history}.
package sonic_pkg;

  localparam int WORD_W  = 64;
  localparam int SCR_LEN = 58;
  localparam int SCR_TAP = 39;
  localparam int DESCR_W = WORD_W + SCR_LEN;

  // ext[j] is the wire bit j-58 positions relative to bit 0 of the current word,
  // so ext[i+58] is "now", ext[i+19] is 39 bits back, ext[i] is 58 bits back.
  function automatic logic [DESCR_W-1:0] descramble64(input logic [WORD_W-1:0]  data,
                                                      input logic [SCR_LEN-1:0] hist);
    logic [DESCR_W-1:0] ext;
    logic [WORD_W-1:0]  descr;
    ext = {data, hist};
    for (int i = 0; i < WORD_W; i++) begin
      descr[i] = ext[i+SCR_LEN] ^ ext[i+SCR_LEN-SCR_TAP] ^ ext[i];
    end
    return {descr, data[WORD_W-1:WORD_W-SCR_LEN]};
  endfunction

endpackage

// File: rtl/sonic_sync_fifo.sv
// Show-ahead FIFO: head is visible combinationally; when empty, head holds the last popped word.
// Push while full is ignored unless a pop happens on the same edge.
module sonic_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset: it is only observed through head while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sonic_upstream_descrambler.sv
// Self-synchronising 64b descrambler behind the 40->64 gearbox; valid in at N gives data_out_valid at N+2.
// Output FIFO absorbs consumer backpressure; overflow drops are sticky. SONIC_DESCR_STATS_EN adds word_cnt/drop_cnt.
module sonic_upstream_descrambler
  import sonic_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             overflow,
  output logic             primed
`ifdef SONIC_DESCR_STATS_EN
  ,
  output logic [31:0]      word_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  logic [SCR_LEN-1:0] hist;
  logic [DESCR_W-1:0] res;
  logic [WIDTH-1:0]   descr_data;
  logic               descr_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop_fire;
  logic               drop;

  assign res            = descramble64(data_in, hist);
  assign data_out_valid = !fifo_empty;
  assign pop_fire       = data_out_valid && data_out_ready;
  assign drop           = descr_valid && fifo_full && !pop_fire;

  // The first word after reset only seeds the history; its output would be garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      primed      <= 1'b0;
      descr_valid <= 1'b0;
      descr_data  <= '0;
      overflow    <= 1'b0;
    end else begin
      descr_valid <= 1'b0;
      if (data_in_valid) begin
        hist   <= res[SCR_LEN-1:0];
        primed <= 1'b1;
        if (primed) begin
          descr_valid <= 1'b1;
          descr_data  <= res[DESCR_W-1:SCR_LEN];
        end
      end
      if (drop) overflow <= 1'b1;
    end
  end

  sonic_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (descr_valid),
    .push_data (descr_data),
    .pop       (data_out_ready),
    .head      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SONIC_DESCR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (pop_fire) word_cnt <= word_cnt + 32'd1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sonic_upstream_descrambler.sv
// Directed bench: serial reference scrambler feeds the DUT, plaintext is the expected output.
module tb_sonic_upstream_descrambler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic        overflow;
  logic        primed;
`ifdef SONIC_DESCR_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [57:0] sc = '0;

  always #5 clk = ~clk;

  sonic_upstream_descrambler #(.WIDTH(64), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .overflow       (overflow),
    .primed         (primed)
`ifdef SONIC_DESCR_STATS_EN
    ,
    .word_cnt       (word_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  // Bit-serial scrambler: s = p ^ s(t-39) ^ s(t-58); sc[k] holds s(t-58+k).
  task automatic scramble(input logic [63:0] p, output logic [63:0] s);
    logic b;
    for (int i = 0; i < 64; i++) begin
      b    = p[i] ^ sc[19] ^ sc[0];
      s[i] = b;
      sc   = {b, sc[57:1]};
    end
  endtask

  // Drive inputs just after a negedge, then return at the next negedge (one posedge later).
  task automatic step(input logic v, input logic [63:0] d, input logic r);
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    data_in_valid  = 1'b0;
    data_in        = '0;
    data_out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_words(input int n, input logic r, output logic [63:0] p [16]);
    logic [63:0] s;
    for (int k = 0; k < n; k++) begin
      p[k] = {$urandom, $urandom};
      scramble(p[k], s);
      step(1'b1, s, r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    chk("reset_data_out", data_out, 64'h0);
    chk("reset_valid", {63'h0, data_out_valid}, 64'h0);
    chk("reset_overflow", {63'h0, overflow}, 64'h0);
    chk("reset_primed", {63'h0, primed}, 64'h0);
    do_reset();
  endtask

  task automatic test_prime_vector();
    do_reset();
    step(1'b1, 64'h0, 1'b1);
    chk("prime_primed", {63'h0, primed}, 64'h1);
    chk("prime_no_push", {63'h0, data_out_valid}, 64'h0);
    step(1'b1, 64'h1, 1'b1);
    chk("prime_latency1_invalid", {63'h0, data_out_valid}, 64'h0);
    step(1'b0, 64'h0, 1'b1);
    chk("vec_valid", {63'h0, data_out_valid}, 64'h1);
    chk("vec_data", data_out, 64'h0400_0080_0000_0001);
    step(1'b0, 64'h0, 1'b1);
    chk("vec_popped", {63'h0, data_out_valid}, 64'h0);
    chk("vec_hold_last", data_out, 64'h0400_0080_0000_0001);
  endtask

  task automatic test_gearbox_stream();
    logic        exp_v [1604];
    logic [63:0] exp_d [1604];
    logic [7:0]  mask;
    logic [63:0] p, s;
    logic        seeded;
    int          bad;
    mask   = 8'b0101_1011;
    seeded = 1'b0;
    bad    = 0;
    do_reset();
    for (int i = 0; i < 1604; i++) begin
      if (i >= 2) begin
        checks++;
        if (data_out_valid !== exp_v[i-2] || (exp_v[i-2] && data_out !== exp_d[i-2])) begin
          errors++;
          if (bad < 5)
            $display("FAIL stream cycle %0d: got v=%b d=%h expected v=%b d=%h",
                     i, data_out_valid, data_out, exp_v[i-2], exp_d[i-2]);
          bad++;
        end
      end else begin
        chk("stream_start_idle", {63'h0, data_out_valid}, 64'h0);
      end
      exp_v[i] = 1'b0;
      exp_d[i] = '0;
      if (i < 1600 && mask[i%8]) begin
        p = {$urandom, $urandom};
        scramble(p, s);
        exp_v[i] = seeded;
        exp_d[i] = p;
        seeded   = 1'b1;
        step(1'b1, s, 1'b1);
      end else begin
        step(1'b0, 64'h0, 1'b1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] p [16];
    do_reset();
    send_words(7, 1'b0, p);  // p[0] primes, p[1..6] pushed
    step(1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    chk("ovf_flag", {63'h0, overflow}, 64'h1);
    chk("ovf_valid", {63'h0, data_out_valid}, 64'h1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_data", data_out, p[k]);
      chk("ovf_drain_valid", {63'h0, data_out_valid}, 64'h1);
      step(1'b0, 64'h0, 1'b1);
    end
    chk("ovf_empty", {63'h0, data_out_valid}, 64'h0);
    chk("ovf_hold_last", data_out, p[4]);
    step(1'b0, 64'h0, 1'b1);
    chk("ovf_empty_pop_ignored", {63'h0, data_out_valid}, 64'h0);
    chk("ovf_sticky", {63'h0, overflow}, 64'h1);
  endtask

  task automatic test_full_push_pop();
    logic [63:0] p [16];
    do_reset();
    send_words(6, 1'b0, p);  // prime + p[1..5]; p[4] fills FIFO on p[5]'s edge
    step(1'b0, 64'h0, 1'b1); // p[5] pushes while p[1] pops
    step(1'b0, 64'h0, 1'b0);
    chk("fpp_no_overflow", {63'h0, overflow}, 64'h0);
    for (int k = 2; k <= 5; k++) begin
      chk("fpp_order", data_out, p[k]);
      step(1'b0, 64'h0, 1'b1);
    end
    chk("fpp_empty", {63'h0, data_out_valid}, 64'h0);
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] p [16];
    logic [63:0] q [16];
    do_reset();
    send_words(4, 1'b0, p);
    chk("mid_valid_before", {63'h0, data_out_valid}, 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_data_zero", data_out, 64'h0);
    chk("mid_valid_zero", {63'h0, data_out_valid}, 64'h0);
    chk("mid_primed_zero", {63'h0, primed}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    send_words(2, 1'b0, q);
    step(1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    chk("mid_one_word_data", data_out, q[1]);
    step(1'b0, 64'h0, 1'b1);
    chk("mid_only_one_word", {63'h0, data_out_valid}, 64'h0);
  endtask

`ifdef SONIC_DESCR_STATS_EN
  task automatic test_stats();
    logic [63:0] p [16];
    do_reset();
    send_words(8, 1'b0, p);  // prime + 7; last 3 dropped
    step(1'b0, 64'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 1'b1);
    send_words(6, 1'b1, p);
    for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 1'b1);
    chk("stats_word_cnt", {32'h0, word_cnt}, 64'd10);
    chk("stats_drop_cnt", {48'h0, drop_cnt}, 64'd3);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_prime_vector();
    test_gearbox_stream();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_burst();
`ifdef SONIC_DESCR_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
